// File: rtl/gate_round_timer_pkg.sv
// Shared state encoding and field widths for the gate round timer.
package gate_round_timer_pkg;

    localparam int SEC_W   = 7;
    localparam int SCORE_W = 4;
    localparam int BLANK_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_BLANK   = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_WIN     = 3'd4
    } state_t;

endpackage

// File: rtl/gate_round_timer_if.sv
// Controller-side inputs and display-side outputs of the round timer.
// master drives timer_en/hit/miss; slave is the timer itself.
interface gate_round_timer_if;
    import gate_round_timer_pkg::*;

    logic               timer_en;
    logic               hit;
    logic               miss;
    logic [SEC_W-1:0]   seconds_left;
    logic [SCORE_W-1:0] score;
    logic               vga_blank;
    logic               running;
    logic               game_over;
    logic               game_won;

    modport master (
        output timer_en, hit, miss,
        input  seconds_left, score, vga_blank, running, game_over, game_won
    );

    modport slave (
        input  timer_en, hit, miss,
        output seconds_left, score, vga_blank, running, game_over, game_won
    );

endinterface

// File: rtl/gate_round_timer_sec_tick_gen.sv
// One-cycle tick every TICK_CYCLES enabled cycles; clear restarts the phase.
// Latency: tick is combinational from the counter; no backpressure.
module sec_tick_gen #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gate_round_timer.sv
// Round countdown, score, timed miss-penalty blank and win/timeout end states.
// Latency: all outputs registered, one cycle after input or tick; no backpressure.
module gate_round_timer
    import gate_round_timer_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int ROUND_SECS  = 60,
    parameter int BLANK_SECS  = 2,
    parameter int MAX_SCORE   = 9
) (
    input  logic              clk,
    input  logic              resetn,
    gate_round_timer_if.slave bus
);

    localparam logic [SEC_W-1:0]   ROUND_V = SEC_W'(ROUND_SECS);
    localparam logic [BLANK_W-1:0] BLANK_V = BLANK_W'(BLANK_SECS);
    localparam logic [SCORE_W-1:0] MAX_V   = SCORE_W'(MAX_SCORE);

    state_t               state_q, state_n;
    logic [SEC_W-1:0]     sec_q, sec_n;
    logic [SCORE_W-1:0]   score_q, score_n;
    logic [BLANK_W-1:0]   bcnt_q, bcnt_n;
    logic                 timer_en_q;
    logic                 vga_blank_q, running_q, over_q, won_q;
    logic                 start, tick, tick_en, tick_clr, idle_like;

    assign start     = bus.timer_en & ~timer_en_q;
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_TIMEOUT) || (state_q == ST_WIN);
    assign tick_en   = (state_q == ST_RUN) || (state_q == ST_BLANK);
    // Only a start that actually launches a round may reset the tick phase.
    assign tick_clr  = start && idle_like;

    sec_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    always_comb begin
        state_n = state_q;
        sec_n   = sec_q;
        score_n = score_q;
        bcnt_n  = bcnt_q;
        case (state_q)
            ST_IDLE, ST_TIMEOUT, ST_WIN: begin
                if (start) begin
                    state_n = ST_RUN;
                    sec_n   = ROUND_V;
                    score_n = '0;
                    bcnt_n  = '0;
                end
            end
            ST_RUN: begin
                // Expiry beats miss beats hit within one cycle.
                if (tick && sec_q <= SEC_W'(1)) begin
                    state_n = ST_TIMEOUT;
                    sec_n   = '0;
                end else begin
                    if (tick) sec_n = sec_q - SEC_W'(1);
                    if (bus.miss) begin
                        state_n = ST_BLANK;
                        bcnt_n  = BLANK_V;
                    end else if (bus.hit && score_q < MAX_V) begin
                        score_n = score_q + SCORE_W'(1);
                        if (score_n == MAX_V) state_n = ST_WIN;
                    end
                end
            end
            ST_BLANK: begin
                if (tick) begin
                    if (sec_q <= SEC_W'(1)) begin
                        state_n = ST_TIMEOUT;
                        sec_n   = '0;
                        bcnt_n  = '0;
                    end else begin
                        sec_n = sec_q - SEC_W'(1);
                        if (bcnt_q <= BLANK_W'(1)) begin
                            state_n = ST_RUN;
                            bcnt_n  = '0;
                        end else begin
                            bcnt_n = bcnt_q - BLANK_W'(1);
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sec_q       <= ROUND_V;
            score_q     <= '0;
            bcnt_q      <= '0;
            timer_en_q  <= 1'b0;
            vga_blank_q <= 1'b0;
            running_q   <= 1'b0;
            over_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            sec_q       <= sec_n;
            score_q     <= score_n;
            bcnt_q      <= bcnt_n;
            timer_en_q  <= bus.timer_en;
            vga_blank_q <= (state_n == ST_BLANK);
            running_q   <= (state_n == ST_RUN) || (state_n == ST_BLANK);
            over_q      <= (state_n == ST_TIMEOUT);
            won_q       <= (state_n == ST_WIN);
        end
    end

    assign bus.seconds_left = sec_q;
    assign bus.score        = score_q;
    assign bus.vga_blank    = vga_blank_q;
    assign bus.running      = running_q;
    assign bus.game_over    = over_q;
    assign bus.game_won     = won_q;

endmodule

// File: tb/tb_gate_round_timer.sv
// Directed-vector bench for gate_round_timer with a short tick period.
module tb_gate_round_timer;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_bad;

    gate_round_timer_if bus ();

    gate_round_timer #(
        .TICK_CYCLES (4),
        .ROUND_SECS  (5),
        .BLANK_SECS  (2),
        .MAX_SCORE   (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, ten, hit, miss;
        logic [6:0] sec;
        logic [3:0] score;
        logic       blank, run, over, won;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, t, h, m, input int s, input int sc,
                               input logic b, ru, o, w);
        vec_t x;
        x.rst_n = r; x.ten = t; x.hit = h; x.miss = m;
        x.sec = 7'(s); x.score = 4'(sc);
        x.blank = b; x.run = ru; x.over = o; x.won = w;
        return x;
    endfunction

    task automatic check(input string name, input int s, input int sc,
                         input logic b, ru, o, w);
        logic [14:0] act, exp;
        act = {bus.seconds_left, bus.score, bus.vga_blank, bus.running, bus.game_over, bus.game_won};
        exp = {7'(s), 4'(sc), b, ru, o, w};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got sec=%0d score=%0d blank=%b run=%b over=%b won=%b, want sec=%0d score=%0d blank=%b run=%b over=%b won=%b",
                     name, act[14:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[14:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive at the falling edge, let one rising edge sample, read at the next falling edge.
    task automatic step(input logic r, t, h, m);
        resetn       = r;
        bus.timer_en = t;
        bus.hit      = h;
        bus.miss     = m;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        resetn = 1'b0;
        bus.timer_en = 1'b0;
        bus.hit = 1'b0;
        bus.miss = 1'b0;

        // r t h m | sec score blank run over won   (start at row 2, ticks on rows 6,10,14,18,22)
        tbl.push_back(v(0,0,0,0, 5,0, 0,0,0,0));
        tbl.push_back(v(1,0,0,0, 5,0, 0,0,0,0));
        tbl.push_back(v(1,1,0,0, 5,0, 0,1,0,0));
        tbl.push_back(v(1,1,1,0, 5,1, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 5,1, 0,1,0,0));
        tbl.push_back(v(1,1,1,0, 5,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 4,2, 0,1,0,0));
        tbl.push_back(v(1,1,1,1, 4,2, 1,1,0,0));
        tbl.push_back(v(1,1,1,0, 4,2, 1,1,0,0));
        tbl.push_back(v(1,1,0,1, 4,2, 1,1,0,0));
        tbl.push_back(v(1,1,0,0, 3,2, 1,1,0,0));
        tbl.push_back(v(1,1,0,0, 3,2, 1,1,0,0));
        tbl.push_back(v(1,1,0,0, 3,2, 1,1,0,0));
        tbl.push_back(v(1,1,0,0, 3,2, 1,1,0,0));
        tbl.push_back(v(1,1,0,0, 2,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 2,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 2,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 2,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 1,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 1,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 1,2, 0,1,0,0));
        tbl.push_back(v(1,1,0,0, 1,2, 0,1,0,0));
        tbl.push_back(v(1,1,1,0, 0,2, 0,0,1,0));
        tbl.push_back(v(1,1,1,0, 0,2, 0,0,1,0));
        tbl.push_back(v(1,1,0,1, 0,2, 0,0,1,0));
        tbl.push_back(v(1,0,0,0, 0,2, 0,0,1,0));
        tbl.push_back(v(1,1,0,0, 5,0, 0,1,0,0));
        tbl.push_back(v(1,1,1,0, 5,1, 0,1,0,0));
        tbl.push_back(v(1,1,1,0, 5,2, 0,1,0,0));
        tbl.push_back(v(1,1,1,0, 5,3, 0,0,0,1));
        tbl.push_back(v(1,1,1,0, 5,3, 0,0,0,1));
        tbl.push_back(v(1,1,0,1, 5,3, 0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].ten, tbl[i].hit, tbl[i].miss);
            check($sformatf("vec%0d", i), int'(tbl[i].sec), int'(tbl[i].score),
                  tbl[i].blank, tbl[i].run, tbl[i].over, tbl[i].won);
        end

        // WIN freezes the countdown.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            check($sformatf("win_hold%0d", i), 5, 3, 0, 0, 0, 1);
        end

        // Restart from WIN, reach BLANK with score 2, then reset asynchronously.
        step(1, 0, 0, 0); check("win_fall", 5, 3, 0, 0, 0, 1);
        step(1, 1, 0, 0); check("win_restart", 5, 0, 0, 1, 0, 0);
        step(1, 1, 1, 0); check("r2_hit1", 5, 1, 0, 1, 0, 0);
        step(1, 1, 1, 0); check("r2_hit2", 5, 2, 0, 1, 0, 0);
        step(1, 1, 0, 1); check("r2_miss", 5, 2, 1, 1, 0, 0);
        step(1, 1, 0, 0); check("r2_blank_tick", 4, 2, 1, 1, 0, 0);
        resetn = 1'b0;
        bus.timer_en = 1'b0;
        #1;
        check("async_reset", 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(0, 0, 0, 0); check("reset_held", 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0); check("idle0", 5, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0); check("idle_hit", 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1); check("idle_miss", 5, 0, 0, 0, 0, 0);

        // Miss two cycles into a round; window spans two ticks.
        step(1, 1, 0, 0); check("r3_start", 5, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0); check("r3_c1", 5, 0, 0, 1, 0, 0);
        step(1, 1, 0, 1); check("r3_miss", 5, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0); check("r3_blank_hit", 5, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0); check("r3_tick1", 4, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0); check("r3_blank_hit2", 4, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0); check("r3_blank_hit3", 4, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0); check("r3_blank_hit4", 4, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0); check("r3_unblank", 3, 0, 0, 1, 0, 0);
        step(1, 1, 1, 0); check("r3_hit_after", 3, 1, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
